// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package : mem_pkg
//  Shared types and constants for the data-memory responder.
//  Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Width of the wait-state counter (supports 0..15 wait states)
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_lane_sram.sv
`default_nettype none
// ============================================================================
//  Module  : byte_lane_sram
//  Word-organised storage array with per-byte write enables, synchronous
//  write and combinational read. Contents are not reset.
//  Ports:
//    clk      in   clock, rising edge
//    i_we     in   per-byte write enable (one bit per 8-bit lane)
//    i_idx    in   word index, shared by read and write
//    i_wdata  in   lane-aligned write data
//    o_rdata  out  word at i_idx
//  Revision: 1.0 - initial release
// ============================================================================
module byte_lane_sram #(
  parameter  int DATA_W      = 32,
  parameter  int DEPTH_WORDS = 1024,
  localparam int NBYTES      = DATA_W / 8,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [NBYTES-1:0] i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (i_we[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_responder
//  Memory-side responder for the core data port. Accepts one load/store at a
//  time over valid/ready, waits WAIT_CYCLES, performs the access against a
//  byte-lane SRAM and returns read data or a write ack (with fault flag).
//  Ports:
//    clk        in   clock, rising edge
//    rst        in   asynchronous reset, active low
//    req_valid  in   request present
//    req_ready  out  responder can accept a request (IDLE, out of reset)
//    req_we     in   1 = store, 0 = load
//    req_addr   in   byte address (word aligned)
//    req_wdata  in   lane-aligned store data
//    req_mask   in   store byte enables
//    rsp_valid  out  response present
//    rsp_ready  in   requester takes the response
//    rsp_rdata  out  load word; 0 for stores and faults
//    rsp_err    out  misaligned or out-of-range access
//  Revision: 1.0 - initial release
// ============================================================================
module dmem_responder
  import mem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_mask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);

  localparam logic [ADDR_W-1:0]     c_lane_mask = ADDR_W'(NBYTES - 1);
  // One bit wider than the address so the span itself cannot overflow
  localparam logic [ADDR_W:0]       c_span      = (ADDR_W+1)'(DEPTH_WORDS * NBYTES);
  localparam logic [WAIT_CNT_W-1:0] c_wait      = WAIT_CNT_W'(WAIT_CYCLES);

  rsp_state_t r_state;
  rsp_state_t w_state_nxt;

  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [NBYTES-1:0]     r_mask;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_accept;
  logic                  w_access;
  logic                  w_rsp_done;
  logic                  w_in_idle;
  logic                  w_acc_we;
  logic [ADDR_W-1:0]     w_acc_addr;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic [NBYTES-1:0]     w_acc_mask;
  logic [ADDR_W-1:0]     w_off;
  logic [ADDR_W-1:0]     w_word;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_fault;
  logic [NBYTES-1:0]     w_sram_we;
  logic [DATA_W-1:0]     w_sram_rdata;
  logic                  w_unused;

  // Ready is gated by reset so nothing is accepted while reset is held
  assign req_ready  = (r_state == RSP_IDLE) && rst;
  assign rsp_valid  = (r_state == RSP_RESP);
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign w_accept   = req_valid && req_ready;
  assign w_rsp_done = rsp_valid && rsp_ready;

  // With zero wait states the access happens on the accept edge, so the
  // live request fields are used instead of the (not yet loaded) latch.
  assign w_in_idle   = (r_state == RSP_IDLE);
  assign w_acc_we    = w_in_idle ? req_we    : r_we;
  assign w_acc_addr  = w_in_idle ? req_addr  : r_addr;
  assign w_acc_wdata = w_in_idle ? req_wdata : r_wdata;
  assign w_acc_mask  = w_in_idle ? req_mask  : r_mask;

  // Below-base addresses are flagged explicitly so a wrapped offset can
  // never land inside the array.
  assign w_off   = w_acc_addr - BASE_ADDR;
  assign w_fault = (w_acc_addr < BASE_ADDR) ||
                   ({1'b0, w_off} >= c_span) ||
                   ((w_acc_addr & c_lane_mask) != '0);
  assign w_word  = w_off >> LANE_W;
  assign w_idx   = w_word[IDX_W-1:0];
  assign w_unused = ^w_word;

  assign w_sram_we = (w_access && w_acc_we && !w_fault) ? w_acc_mask : '0;

  byte_lane_sram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_sram_we),
    .i_idx   (w_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_sram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RSP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    case (r_state)
      RSP_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_access    = 1'b1;
            w_state_nxt = RSP_RESP;
          end else begin
            w_state_nxt = RSP_WAIT;
          end
        end
      end
      RSP_WAIT: begin
        if (r_cnt == WAIT_CNT_W'(1)) begin
          w_access    = 1'b1;
          w_state_nxt = RSP_RESP;
        end
      end
      RSP_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = RSP_IDLE;
        end
      end
      default: w_state_nxt = RSP_IDLE;
    endcase
  end

  // Request latch and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
    end else if (w_accept) begin
      r_cnt   <= c_wait;
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_mask  <= req_mask;
    end else if (r_state == RSP_WAIT) begin
      r_cnt <= r_cnt - WAIT_CNT_W'(1);
    end
  end

  // Response registers: loaded at the access, cleared once handed over
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_access) begin
      r_rsp_rdata <= (w_acc_we || w_fault) ? '0 : w_sram_rdata;
      r_rsp_err   <= w_fault;
    end else if (w_rsp_done) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end
  end

endmodule
`default_nettype wire
